intersection_scheduler: RTL and testbench
=========================================

INTERSECTION_SCHEDULER -- requirements
Module: intersection_scheduler

Interface
REQ-001 Parameter GREEN_MIN, default 20: minimum green duration in cycles; must be at least 1.
REQ-002 Parameter GREEN_MAX, default 60: maximum green duration in cycles while competing demand exists; must be at least GREEN_MIN.
REQ-003 Parameter YELLOW_T, default 10: yellow duration in cycles; must be at least 1.
REQ-004 Parameter ALLRED_T, default 4: all-red clearance duration in cycles; must be at least 1.
REQ-005 Parameter WALK_T, default 30: pedestrian walk duration in cycles; must be at least 1.
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 ns_req  input  1  vehicle present on the north-south approach (level).
REQ-009 ew_req  input  1  vehicle present on the east-west approach (level).
REQ-010 ped_req  input  1  pedestrian button; any cycle it is high counts as a request.
REQ-011 ns_light  output  3  north-south lamp, one-hot: 001 red, 010 yellow, 100 green.
REQ-012 ew_light  output  3  east-west lamp, same encoding as ns_light.
REQ-013 walk  output  1  pedestrian walk indication.
REQ-014 ped_pending  output  1  latched, not-yet-served pedestrian request.
REQ-015 phase  output  3  current state code (encoding in REQ-017), for debug.

Function
REQ-016 All outputs SHALL be registered or decoded only from registered state; no input-to-output combinational path.
REQ-017 The FSM SHALL have these states and phase codes:
- ALLRED=0
- NS_GREEN=1
- NS_YELLOW=2
- EW_GREEN=3
- EW_YELLOW=4
- PED_WALK=5
REQ-018 The state timer SHALL clear to 0 on every state entry and increment by 1 per cycle; it SHALL saturate at GREEN_MAX-1 and never wrap.
REQ-019 Lamp mapping per state:
- NS_GREEN: ns 100, ew 001.
- NS_YELLOW: ns 010, ew 001.
- EW_GREEN: ns 001, ew 100.
- EW_YELLOW: ns 001, ew 010.
- ALLRED and PED_WALK: ns 001, ew 001.
REQ-020 walk SHALL be 1 only in PED_WALK.
REQ-021 ns_light and ew_light SHALL never be non-red in the same cycle.
REQ-022 Competing demand during X_GREEN SHALL be (other-direction req OR ped_pending).
REQ-023 X_GREEN SHALL go to X_YELLOW only when competing demand is present and either condition holds:
- gap-out: timer >= GREEN_MIN-1 and own req = 0;
- max-out: timer = GREEN_MAX-1.
REQ-024 Without competing demand, X_GREEN SHALL hold indefinitely.
REQ-025 X_YELLOW SHALL last exactly YELLOW_T cycles, then go to ALLRED.
REQ-026 Register next_dir SHALL select the green served after ALLRED; it SHALL be set to the opposite direction when leaving X_YELLOW.
REQ-027 ALLRED SHALL last exactly ALLRED_T cycles, then:
- PED_WALK if ped_pending = 1;
- otherwise the green selected by next_dir.
REQ-028 PED_WALK SHALL last exactly WALK_T cycles, then go to ALLRED with next_dir unchanged.
REQ-029 ped_pending SHALL set on any cycle with ped_req = 1 outside PED_WALK, and clear on the edge entering PED_WALK.
REQ-030 ped_req during PED_WALK SHALL be ignored.
REQ-031 If ped_req is high on the cycle ALLRED exits to PED_WALK, the clear SHALL win.
REQ-032 Vehicle reqs SHALL be sampled only as in REQ-023.
REQ-033 Both vehicle reqs high SHALL have no effect beyond REQ-023; alternation via next_dir guarantees service.

Reset
REQ-034 With reset high at a rising edge, the block SHALL enter the following on that edge, regardless of current state:
- state ALLRED, timer 0, next_dir NS, ped_pending 0;
- outputs ns 001, ew 001, walk 0, phase 0.
REQ-035 Reset asserted mid-phase (e.g. in NS_GREEN or PED_WALK) SHALL abandon that phase with no yellow.
REQ-036 After release, the first green SHALL be NS, ALLRED_T cycles after the first edge with reset low.

Verification
Bench parameters for all scenarios: GREEN_MIN=4, GREEN_MAX=10, YELLOW_T=3, ALLRED_T=2, WALK_T=5.
REQ-037 Reset for 2 cycles, no requests -> ns/ew 001/001 for 2 cycles, then ns 100 held for 50+ cycles; ew stays 001 and walk stays 0.
REQ-038 In NS_GREEN, hold ns_req=1 and raise ew_req=1 at timer 0 -> max-out: ns 100 for 10 cycles, 010 for 3, all-red for 2, then ew 100.
REQ-039 In NS_GREEN, set ew_req=1 and ns_req=0 -> gap-out after 4 cycles: ns 010 next, then the EW green sequence.
REQ-040 1-cycle ped_req pulse in EW_GREEN, plus ns_req=1 -> ped_pending=1, then EW yellow, ALLRED, and walk=1 for 5 cycles (ped_pending=0 on entry), then ALLRED, then ns 100.
REQ-041 ped_req pulsed during PED_WALK -> ped_pending stays 0 and the next phase after ALLRED is vehicle green.
REQ-042 Reset asserted at timer 2 of PED_WALK -> next edge gives phase 0, walk 0, ped_pending 0; the REQ-037 sequence then repeats.
REQ-043 Assertion on all scenarios: ns_light and ew_light are never both non-red, and walk=1 only when both lamps = 001.

Source files
------------

// File: rtl/intersection_scheduler.sv
// Two-approach traffic signal controller with a latched pedestrian walk phase.
// Lamps, walk and phase are decoded only from registered state.
module intersection_scheduler #(
  parameter int unsigned GREEN_MIN = 20,
  parameter int unsigned GREEN_MAX = 60,
  parameter int unsigned YELLOW_T  = 10,
  parameter int unsigned ALLRED_T  = 4,
  parameter int unsigned WALK_T    = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ns_req,
  input  logic       ew_req,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  localparam logic [2:0] ALLRED    = 3'd0;
  localparam logic [2:0] NS_GREEN  = 3'd1;
  localparam logic [2:0] NS_YELLOW = 3'd2;
  localparam logic [2:0] EW_GREEN  = 3'd3;
  localparam logic [2:0] EW_YELLOW = 3'd4;
  localparam logic [2:0] PED_WALK  = 3'd5;

  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

  localparam logic [2:0] LAMP_RED    = 3'b001;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b100;

  // Timer saturates at GREEN_MAX-1; widened only if a fixed phase is longer,
  // so an oversized yellow/all-red/walk can still time out.
  localparam int unsigned TMAX_A = (GREEN_MAX > WALK_T)   ? GREEN_MAX : WALK_T;
  localparam int unsigned TMAX_B = (YELLOW_T  > ALLRED_T) ? YELLOW_T  : ALLRED_T;
  localparam int unsigned TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
  localparam int unsigned TW     = (TMAX > 2) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] T_SAT    = TW'(TMAX - 1);
  localparam logic [TW-1:0] GMIN_END = TW'(GREEN_MIN - 1);
  localparam logic [TW-1:0] GMAX_END = TW'(GREEN_MAX - 1);
  localparam logic [TW-1:0] Y_END    = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] AR_END   = TW'(ALLRED_T - 1);
  localparam logic [TW-1:0] WALK_END = TW'(WALK_T - 1);

  logic [2:0]    state, state_nxt;
  logic [TW-1:0] timer;
  logic          next_dir, next_dir_nxt;
  logic          gap_ok, max_ok;

  assign gap_ok = (timer >= GMIN_END);
  assign max_ok = (timer >= GMAX_END);

  always_comb begin
    state_nxt    = state;
    next_dir_nxt = next_dir;
    case (state)
      ALLRED: begin
        if (timer == AR_END) begin
          if (ped_pending)             state_nxt = PED_WALK;
          else if (next_dir == DIR_EW) state_nxt = EW_GREEN;
          else                         state_nxt = NS_GREEN;
        end
      end
      NS_GREEN: begin
        if ((ew_req || ped_pending) && ((gap_ok && !ns_req) || max_ok))
          state_nxt = NS_YELLOW;
      end
      NS_YELLOW: begin
        if (timer == Y_END) begin
          state_nxt    = ALLRED;
          next_dir_nxt = DIR_EW;
        end
      end
      EW_GREEN: begin
        if ((ns_req || ped_pending) && ((gap_ok && !ew_req) || max_ok))
          state_nxt = EW_YELLOW;
      end
      EW_YELLOW: begin
        if (timer == Y_END) begin
          state_nxt    = ALLRED;
          next_dir_nxt = DIR_NS;
        end
      end
      PED_WALK: begin
        if (timer == WALK_END) state_nxt = ALLRED;
      end
      default: state_nxt = ALLRED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ALLRED;
      timer       <= '0;
      next_dir    <= DIR_NS;
      ped_pending <= 1'b0;
    end else begin
      state    <= state_nxt;
      next_dir <= next_dir_nxt;
      if (state_nxt != state)  timer <= '0;
      else if (timer != T_SAT) timer <= timer + TW'(1);
      // Entering the walk clears the latch even if the button is held that cycle.
      if (state_nxt == PED_WALK && state != PED_WALK) ped_pending <= 1'b0;
      else if (ped_req && state != PED_WALK)          ped_pending <= 1'b1;
    end
  end

  always_comb begin
    ns_light = LAMP_RED;
    ew_light = LAMP_RED;
    walk     = 1'b0;
    case (state)
      NS_GREEN:  ns_light = LAMP_GREEN;
      NS_YELLOW: ns_light = LAMP_YELLOW;
      EW_GREEN:  ew_light = LAMP_GREEN;
      EW_YELLOW: ew_light = LAMP_YELLOW;
      PED_WALK:  walk     = 1'b1;
      default: ;
    endcase
  end

  assign phase = state;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Directed bench for intersection_scheduler: a table of input rows, each held
// for n cycles with the outputs expected after every one of those edges.
module tb_intersection_scheduler;

  localparam logic [2:0] R = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b100;

  typedef struct {
    logic       rst;
    logic       ns;
    logic       ew;
    logic       ped;
    int         n;
    logic [2:0] ph;
    logic [2:0] nsl;
    logic [2:0] ewl;
    logic       wk;
    logic       pp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ns_req = 1'b0, ew_req = 1'b0, ped_req = 1'b0;
  logic [2:0] ns_light, ew_light, phase;
  logic       walk, ped_pending;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  intersection_scheduler #(
    .GREEN_MIN(4),
    .GREEN_MAX(10),
    .YELLOW_T (3),
    .ALLRED_T (2),
    .WALK_T   (5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ns_req     (ns_req),
    .ew_req     (ew_req),
    .ped_req    (ped_req),
    .ns_light   (ns_light),
    .ew_light   (ew_light),
    .walk       (walk),
    .ped_pending(ped_pending),
    .phase      (phase)
  );

  always #5 clk = ~clk;

  // Safety invariants, checked every cycle once the design is out of X.
  always @(negedge clk) begin
    if (started) begin
      checks++;
      if ((ns_light != R) && (ew_light != R)) begin
        errors++;
        $display("FAIL conflict: ns_light=%b ew_light=%b, required at least one 001", ns_light, ew_light);
      end
      if (walk && !((ns_light == R) && (ew_light == R))) begin
        errors++;
        $display("FAIL walk_red: walk=1 with ns=%b ew=%b, required both 001", ns_light, ew_light);
      end
    end
  end

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic ns, logic ew, logic ped, int n,
                              logic [2:0] ph, logic [2:0] nsl, logic [2:0] ewl,
                              logic wk, logic pp);
    vec_t v;
    v.rst = rst; v.ns = ns; v.ew = ew; v.ped = ped; v.n = n;
    v.ph = ph; v.nsl = nsl; v.ewl = ewl; v.wk = wk; v.pp = pp;
    return v;
  endfunction

  initial begin
    // Power-up reset and idle hold on NS.
    vecs.push_back(mk(1,0,0,0, 2, 3'd0, R,R,0,0));
    vecs.push_back(mk(0,0,0,0, 1, 3'd0, R,R,0,0));
    vecs.push_back(mk(0,0,0,0,50, 3'd1, G,R,0,0));
    // Max-out on NS with both approaches demanding, then EW max-out set-up.
    vecs.push_back(mk(1,1,1,0, 1, 3'd0, R,R,0,0));
    vecs.push_back(mk(0,1,1,0, 1, 3'd0, R,R,0,0));
    vecs.push_back(mk(0,1,1,0,10, 3'd1, G,R,0,0));
    vecs.push_back(mk(0,1,1,0, 3, 3'd2, Y,R,0,0));
    vecs.push_back(mk(0,1,1,0, 2, 3'd0, R,R,0,0));
    vecs.push_back(mk(0,1,1,0, 1, 3'd3, R,G,0,0));
    // EW gap-out after GREEN_MIN, then NS gap-out.
    vecs.push_back(mk(0,1,0,0, 3, 3'd3, R,G,0,0));
    vecs.push_back(mk(0,1,0,0, 3, 3'd4, R,Y,0,0));
    vecs.push_back(mk(0,1,0,0, 2, 3'd0, R,R,0,0));
    vecs.push_back(mk(0,1,0,0, 1, 3'd1, G,R,0,0));
    vecs.push_back(mk(0,0,1,0, 3, 3'd1, G,R,0,0));
    vecs.push_back(mk(0,0,1,0, 3, 3'd2, Y,R,0,0));
    vecs.push_back(mk(0,0,1,0, 2, 3'd0, R,R,0,0));
    vecs.push_back(mk(0,0,1,0, 1, 3'd3, R,G,0,0));
    // Ped pulse in EW green: walk after all-red, then NS green.
    vecs.push_back(mk(0,1,1,1, 1, 3'd3, R,G,0,1));
    vecs.push_back(mk(0,1,1,0, 8, 3'd3, R,G,0,1));
    vecs.push_back(mk(0,1,1,0, 3, 3'd4, R,Y,0,1));
    vecs.push_back(mk(0,1,1,0, 2, 3'd0, R,R,0,1));
    vecs.push_back(mk(0,1,1,0, 5, 3'd5, R,R,1,0));
    vecs.push_back(mk(0,1,1,0, 2, 3'd0, R,R,0,0));
    vecs.push_back(mk(0,1,1,0, 1, 3'd1, G,R,0,0));
    // Ped alone forces NS gap-out; button held into walk entry and during walk.
    vecs.push_back(mk(0,0,0,1, 1, 3'd1, G,R,0,1));
    vecs.push_back(mk(0,0,0,0, 2, 3'd1, G,R,0,1));
    vecs.push_back(mk(0,0,0,0, 3, 3'd2, Y,R,0,1));
    vecs.push_back(mk(0,0,0,0, 2, 3'd0, R,R,0,1));
    vecs.push_back(mk(0,0,0,1, 1, 3'd5, R,R,1,0));
    vecs.push_back(mk(0,0,0,1, 4, 3'd5, R,R,1,0));
    vecs.push_back(mk(0,0,0,0, 2, 3'd0, R,R,0,0));
    vecs.push_back(mk(0,0,0,0, 1, 3'd3, R,G,0,0));
    // Reset at walk timer 2, then the idle sequence again.
    vecs.push_back(mk(0,0,0,1, 1, 3'd3, R,G,0,1));
    vecs.push_back(mk(0,0,0,0, 2, 3'd3, R,G,0,1));
    vecs.push_back(mk(0,0,0,0, 3, 3'd4, R,Y,0,1));
    vecs.push_back(mk(0,0,0,0, 2, 3'd0, R,R,0,1));
    vecs.push_back(mk(0,0,0,0, 3, 3'd5, R,R,1,0));
    vecs.push_back(mk(1,0,0,0, 1, 3'd0, R,R,0,0));
    vecs.push_back(mk(0,0,0,0, 1, 3'd0, R,R,0,0));
    vecs.push_back(mk(0,0,0,0,20, 3'd1, G,R,0,0));
    // Saturated timer: late demand maxes out on the next edge.
    vecs.push_back(mk(0,1,1,0, 1, 3'd2, Y,R,0,0));
    // Reset mid-green abandons the phase with no yellow.
    vecs.push_back(mk(1,0,1,0, 1, 3'd0, R,R,0,0));
    vecs.push_back(mk(0,0,1,0, 1, 3'd0, R,R,0,0));
    vecs.push_back(mk(0,0,1,0, 3, 3'd1, G,R,0,0));
    vecs.push_back(mk(1,0,1,0, 1, 3'd0, R,R,0,0));
    vecs.push_back(mk(0,0,1,0, 1, 3'd0, R,R,0,0));
    // Reset in all-red after NS yellow restores next_dir to NS.
    vecs.push_back(mk(0,0,1,0, 4, 3'd1, G,R,0,0));
    vecs.push_back(mk(0,0,1,0, 3, 3'd2, Y,R,0,0));
    vecs.push_back(mk(0,0,1,0, 1, 3'd0, R,R,0,0));
    vecs.push_back(mk(1,0,1,0, 1, 3'd0, R,R,0,0));
    vecs.push_back(mk(0,0,1,0, 1, 3'd0, R,R,0,0));
    vecs.push_back(mk(0,0,1,0, 1, 3'd1, G,R,0,0));

    foreach (vecs[i]) begin
      reset   = vecs[i].rst;
      ns_req  = vecs[i].ns;
      ew_req  = vecs[i].ew;
      ped_req = vecs[i].ped;
      for (int c = 0; c < vecs[i].n; c++) begin
        @(posedge clk);
        #1;
        started = 1'b1;
        checks++;
        if ({phase, ns_light, ew_light, walk, ped_pending} !==
            {vecs[i].ph, vecs[i].nsl, vecs[i].ewl, vecs[i].wk, vecs[i].pp}) begin
          errors++;
          $display("FAIL row%0d cyc%0d: got phase=%0d ns=%b ew=%b walk=%b pp=%b, required phase=%0d ns=%b ew=%b walk=%b pp=%b",
                   i, c, phase, ns_light, ew_light, walk, ped_pending,
                   vecs[i].ph, vecs[i].nsl, vecs[i].ewl, vecs[i].wk, vecs[i].pp);
        end
      end
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
